// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble-serial datapath (deserializer now,
// serializer later): nibble type, index type, default word size and the
// deserializer FSM state encoding.
package nibble_pkg;

  localparam int NIBBLE_BITS     = 4;
  localparam int DEFAULT_NIBBLES = 8;

  typedef logic [NIBBLE_BITS-1:0] Nibble;
  typedef logic [2:0]             NibbleIdx;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } DeserState;

endpackage

// File: rtl/nibble_deserializer_if.sv
// Bus bundle for the nibble deserializer: nibble input handshake, word
// output handshake, flush and busy. When NIBBLE_DESER_ZERO_FLAG_EN is
// defined the bundle also carries the registered all-zero word flag.
interface nibble_deserializer_if
  import nibble_pkg::*;
#(
  parameter int NIBBLES = DEFAULT_NIBBLES
);

  localparam int W = NIBBLE_BITS * NIBBLES;

  logic           flush;
  logic           in_valid;
  logic           in_ready;
  Nibble          in_nibble;
  logic           in_msb_first;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_word;
  logic           busy;
`ifdef NIBBLE_DESER_ZERO_FLAG_EN
  logic           out_zero;
`endif

  // The deserializer itself.
  modport slave (
    input  flush, in_valid, in_nibble, in_msb_first, out_ready,
`ifdef NIBBLE_DESER_ZERO_FLAG_EN
    output out_zero,
`endif
    output in_ready, out_valid, out_word, busy
  );

  // Whoever feeds nibbles and consumes words.
  modport master (
    output flush, in_valid, in_nibble, in_msb_first, out_ready,
`ifdef NIBBLE_DESER_ZERO_FLAG_EN
    input  out_zero,
`endif
    input  in_ready, out_valid, out_word, busy
  );

endinterface

// File: rtl/nibble_index_counter.sv
// Loadable up/down nibble position counter. Load has priority over step;
// the counter is only ever reloaded at word boundaries by its user, so it
// never needs to wrap in the middle of a word.
module nibble_index_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic             down,
  output logic [WIDTH-1:0] idx
);

  // Position register: reload, otherwise step toward the next nibble slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (load) begin
      idx <= load_val;
    end else if (step) begin
      idx <= down ? idx - WIDTH'(1) : idx + WIDTH'(1);
    end
  end

endmodule

// File: rtl/nibble_deserializer.sv
// Nibble-serial to parallel word assembler. Nibbles arrive LSB-first or
// MSB-first (direction latched with the first nibble of each word) and the
// finished word is held on a valid/ready output until taken. In HOLD the
// input is ready exactly when the output is being taken, so back-to-back
// words lose no cycle. Optional feature macro: NIBBLE_DESER_ZERO_FLAG_EN
// adds out_zero, an all-nibbles-zero flag built up one nibble at a time.
module nibble_deserializer
  import nibble_pkg::*;
#(
  parameter int NIBBLES = DEFAULT_NIBBLES
) (
  input  logic                 clk,
  input  logic                 reset,
  nibble_deserializer_if.slave bus
);

  localparam int W  = NIBBLE_BITS * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam int CW = $clog2(NIBBLES + 1);

  localparam logic [IW-1:0] LAST_POS   = IW'(NIBBLES - 1);
  localparam logic [IW-1:0] MSB_SECOND = IW'(NIBBLES - 2);
  localparam logic [IW-1:0] LSB_SECOND = IW'(1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(NIBBLES - 1);

  DeserState     state, state_n;
  logic          dir, dir_n;
  logic [W-1:0]  asm_reg, asm_n;
  logic [CW-1:0] count, count_n;
  logic [W-1:0]  word_reg, word_n;

  logic          in_ready;
  logic          accept;
  logic          start;
  logic [IW-1:0] first_pos;

  logic          cnt_load;
  logic [IW-1:0] cnt_load_val;
  logic          cnt_step;
  logic [IW-1:0] idx;

`ifdef NIBBLE_DESER_ZERO_FLAG_EN
  logic          zero_acc, zero_acc_n;
  logic          zero_reg, zero_n;
`endif

  nibble_index_counter #(
    .WIDTH (IW)
  ) u_index (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .step     (cnt_step),
    .down     (dir),
    .idx      (idx)
  );

  assign accept    = bus.in_valid && in_ready;
  assign start     = accept && (state != COLLECT);
  assign first_pos = bus.in_msb_first ? LAST_POS : '0;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state == COLLECT);
  assign bus.out_word  = word_reg;
`ifdef NIBBLE_DESER_ZERO_FLAG_EN
  assign bus.out_zero  = zero_reg;
`endif

  // Next-state logic: readiness, nibble placement, completion and the
  // first nibble of a new word (which may overlap taking the held word).
  always_comb begin
    state_n      = state;
    dir_n        = dir;
    asm_n        = asm_reg;
    count_n      = count;
    word_n       = word_reg;
    in_ready     = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_step     = 1'b0;
`ifdef NIBBLE_DESER_ZERO_FLAG_EN
    zero_acc_n   = zero_acc;
    zero_n       = zero_reg;
`endif

    case (state)
      IDLE: begin
        in_ready = !bus.flush;
      end

      COLLECT: begin
        in_ready = !bus.flush;
        if (bus.flush) begin
          state_n = IDLE;
          count_n = '0;
          asm_n   = '0;
`ifdef NIBBLE_DESER_ZERO_FLAG_EN
          zero_acc_n = 1'b0;
`endif
        end else if (accept) begin
          asm_n[idx*NIBBLE_BITS +: NIBBLE_BITS] = bus.in_nibble;
          count_n  = count + CW'(1);
          cnt_step = 1'b1;
`ifdef NIBBLE_DESER_ZERO_FLAG_EN
          zero_acc_n = zero_acc && (bus.in_nibble == '0);
`endif
          if (count == LAST_COUNT) begin
            word_n  = asm_n;
            state_n = HOLD;
`ifdef NIBBLE_DESER_ZERO_FLAG_EN
            zero_n  = zero_acc_n;
`endif
          end
        end
      end

      HOLD: begin
        in_ready = bus.out_ready && !bus.flush;
        if (bus.out_ready) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (start) begin
      state_n      = COLLECT;
      dir_n        = bus.in_msb_first;
      asm_n        = '0;
      asm_n[first_pos*NIBBLE_BITS +: NIBBLE_BITS] = bus.in_nibble;
      count_n      = CW'(1);
      cnt_load     = 1'b1;
      cnt_load_val = bus.in_msb_first ? MSB_SECOND : LSB_SECOND;
`ifdef NIBBLE_DESER_ZERO_FLAG_EN
      zero_acc_n   = (bus.in_nibble == '0);
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dir      <= 1'b0;
      asm_reg  <= '0;
      count    <= '0;
      word_reg <= '0;
`ifdef NIBBLE_DESER_ZERO_FLAG_EN
      zero_acc <= 1'b0;
      zero_reg <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      dir      <= dir_n;
      asm_reg  <= asm_n;
      count    <= count_n;
      word_reg <= word_n;
`ifdef NIBBLE_DESER_ZERO_FLAG_EN
      zero_acc <= zero_acc_n;
      zero_reg <= zero_n;
`endif
    end
  end

endmodule

// File: tb/tb_nibble_deserializer.sv
// Self-checking bench for nibble_deserializer: directed scenarios plus a
// randomized run, all compared against a queue-based reference model of
// the word assembly and handshake rules. Define NIBBLE_DESER_ZERO_FLAG_EN
// to also exercise out_zero.
module tb_nibble_deserializer;
  import nibble_pkg::*;

  localparam int NIB = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  nibble_deserializer_if #(.NIBBLES(NIB)) bus ();

  nibble_deserializer #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: held word state plus a queue of nibbles collected so far.
  bit          m_hold;
  bit          m_dir;
  logic [31:0] m_word;
  bit          m_zero;
  logic [3:0]  q[$];

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic buildWord();
    int pos;
    m_word = '0;
    m_zero = 1'b1;
    foreach (q[i]) begin
      pos = m_dir ? (NIB - 1 - i) : i;
      m_word[pos*4 +: 4] = q[i];
      if (q[i] != 4'h0) m_zero = 1'b0;
    end
  endtask

  // One clock cycle: drive inputs, check outputs on the falling edge, then
  // advance the model on the rising edge.
  task automatic applyStimulus(input bit v, input logic [3:0] n, input bit msb,
                               input bit ordy, input bit fl);
    bit exp_ready, acc, take;
    bus.in_valid     = v;
    bus.in_nibble    = n;
    bus.in_msb_first = msb;
    bus.out_ready    = ordy;
    bus.flush        = fl;
    @(negedge clk);
    exp_ready = fl ? 1'b0 : (m_hold ? ordy : 1'b1);
    checkOutput("in_ready", bus.in_ready, exp_ready);
    checkOutput("out_valid", bus.out_valid, m_hold);
    checkOutput("busy", bus.busy, (!m_hold && q.size() != 0));
    if (m_hold) begin
      checkOutput("out_word", bus.out_word, m_word);
`ifdef NIBBLE_DESER_ZERO_FLAG_EN
      checkOutput("out_zero", bus.out_zero, m_zero);
`endif
    end
    acc  = v && exp_ready;
    take = m_hold && ordy;
    @(posedge clk);
    if (fl && !m_hold) q.delete();
    if (take) m_hold = 1'b0;
    if (acc) begin
      if (q.size() == 0) m_dir = msb;
      q.push_back(n);
      if (q.size() == NIB) begin
        buildWord();
        m_hold = 1'b1;
        q.delete();
      end
    end
    #1;
  endtask

  task automatic doReset();
    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_nibble    = 4'h0;
    bus.in_msb_first = 1'b0;
    bus.out_ready    = 1'b0;
    bus.flush        = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    m_hold = 1'b0;
    q.delete();
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_out_word", bus.out_word, '0);
    checkOutput("rst_in_ready", bus.in_ready, 1'b1);
`ifdef NIBBLE_DESER_ZERO_FLAG_EN
    checkOutput("rst_out_zero", bus.out_zero, 1'b0);
`endif
  endtask

  // Nibble i of the word is nibs[4i+3:4i], sent in order i = 0..NIB-1.
  task automatic feedWord(input logic [31:0] nibs, input bit msb_first,
                          input bit msb_after, input bit ordy);
    for (int i = 0; i < NIB; i++) begin
      applyStimulus(1'b1, nibs[i*4 +: 4], (i == 0) ? msb_first : msb_after, ordy, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    doReset();

    // LSB-first 1..8
    feedWord(32'h87654321, 1'b0, 1'b0, 1'b1);
    checkOutput("lsb_word", bus.out_word, 32'h87654321);
    checkOutput("lsb_valid", bus.out_valid, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // MSB-first 1..8, direction toggled after first nibble
    feedWord(32'h87654321, 1'b1, 1'b0, 1'b1);
    checkOutput("msb_word", bus.out_word, 32'h12345678);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Backpressure, then take + accept in the same cycle
    feedWord(32'hAAAAAAAA, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
      checkOutput("bp_word", bus.out_word, 32'hAAAAAAAA);
    end
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_busy", bus.busy, 1'b1);
    for (int i = 0; i < NIB - 1; i++) applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_next_word", bus.out_word, 32'h00000003);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Flush after three nibbles, with a competing nibble
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_busy", bus.busy, 1'b0);
    feedWord(32'h55555555, 1'b0, 1'b0, 1'b1);
    checkOutput("post_flush_word", bus.out_word, 32'h55555555);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Reset mid-word and in HOLD
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0);
    doReset();
    feedWord(32'h0FEDCBA9, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    doReset();
    feedWord(32'h13572468, 1'b1, 1'b1, 1'b1);
    checkOutput("post_reset_word", bus.out_word, 32'h86427531);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

`ifdef NIBBLE_DESER_ZERO_FLAG_EN
    feedWord(32'h00000000, 1'b0, 1'b0, 1'b1);
    checkOutput("zero_flag_set", bus.out_zero, 1'b1);
    checkOutput("zero_word", bus.out_word, 32'h0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    feedWord(32'h10000000, 1'b0, 1'b0, 1'b1);
    checkOutput("zero_flag_clear", bus.out_zero, 1'b0);
    checkOutput("nonzero_word", bus.out_word, 32'h10000000);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0);
    end
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
